// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch counter: FSM state encoding and display width.
package stopwatch_counter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    localparam int unsigned NumberWidth  = 7;
    // Highest value the two-digit display can show; MAX_COUNT must not exceed it.
    localparam int unsigned MaxCountCeil = 99;

endpackage

// File: rtl/stopwatch_counter_button_conditioner.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-level debouncer and
// rising-edge detector producing a single-cycle registered press pulse.
module stopwatch_counter_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw,
    output logic press_pulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic            level_prev_q, level_prev_d;
    logic            pulse_q, pulse_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Next state: accept a new level only after it has differed from the
    // accepted one for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        level_prev_d = level_q;
        pulse_d      = level_q & ~level_prev_q;
    end

    // Conditioner state registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Two-digit seconds stopwatch: button conditioning, Start/Stop/Clear FSM,
// 1 Hz prescaler and 0..MAX_COUNT counter with registered outputs.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_COUNT       = MaxCountCeil
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   BtnStartStop,
    input  logic                   BtnClear,
    input  logic                   BtnLap,
    output logic [NumberWidth-1:0] Number,
    output logic                   Running,
    output logic                   Wrap,
    output logic                   LapHeld
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0]        PreLast = PreW'(TICK_DIV - 1);
    localparam logic [NumberWidth-1:0] CntMax  = NumberWidth'(MAX_COUNT);

    logic ss_pulse, clr_pulse, lap_pulse, tick;

    state_e                 state_q, state_d;
    logic [PreW-1:0]        presc_q, presc_d;
    logic [NumberWidth-1:0] count_q, count_d;
    logic [NumberWidth-1:0] number_q, number_d;
    logic                   running_q, running_d;
    logic                   wrap_q, wrap_d;
    logic                   lap_q, lap_d;

    stopwatch_counter_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_startstop (
        .Clk        (Clk),
        .Rst        (Rst),
        .raw        (BtnStartStop),
        .press_pulse(ss_pulse)
    );

    stopwatch_counter_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_clear (
        .Clk        (Clk),
        .Rst        (Rst),
        .raw        (BtnClear),
        .press_pulse(clr_pulse)
    );

`ifdef STOPWATCH_LAP_EN
    stopwatch_counter_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_lap (
        .Clk        (Clk),
        .Rst        (Rst),
        .raw        (BtnLap),
        .press_pulse(lap_pulse)
    );
`else
    logic unused_btn_lap;
    assign unused_btn_lap = BtnLap;
    assign lap_pulse      = 1'b0;
`endif

    // Next state for FSM, prescaler, count and lap hold; clear overrides everything.
    always_comb begin
        tick    = (state_q == StRun) && (presc_q == PreLast);
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        lap_d   = lap_q;

        if (clr_pulse) begin
            state_d = StIdle;
            presc_d = '0;
            count_d = '0;
            lap_d   = 1'b0;
        end else begin
            // Prescaler holds in PAUSE so the partial second survives a pause.
            if (state_q == StRun) begin
                presc_d = tick ? '0 : presc_q + PreW'(1);
            end else if (state_q == StIdle) begin
                presc_d = '0;
            end

            if (tick) begin
                if (count_q == CntMax) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + NumberWidth'(1);
                end
            end

            if (ss_pulse) begin
                unique case (state_q)
                    StIdle:  state_d = StRun;
                    StRun:   state_d = StPause;
                    StPause: state_d = StRun;
                    default: state_d = StIdle;
                endcase
            end

            if (lap_pulse && (state_q != StIdle)) begin
                lap_d = ~lap_q;
            end
        end

        running_d = (state_d == StRun);
        // While held, keep showing the value that was on display at press time.
        number_d  = lap_d ? number_q : count_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            count_q   <= '0;
            number_q  <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            lap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            number_q  <= number_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            lap_q     <= lap_d;
        end
    end

    assign Number  = number_q;
    assign Running = running_q;
    assign Wrap    = wrap_q;
    assign LapHeld = lap_q;

endmodule
